// File: rtl/tone_map_pkg.sv
// Shared defaults and types for the tone-map output packer: channel formats,
// frame buffer geometry, writer state encoding and the word FIFO entry layout.
package tone_map_pkg;

  localparam int DEF_FP        = 8;
  localparam int DEF_RED_W     = 5;
  localparam int DEF_GREEN_W   = 6;
  localparam int DEF_BLUE_W    = 5;
  localparam int DEF_DATA_W    = 256;
  localparam int DEF_ADDR_STEP = 4;
  localparam int DEF_FB_WORDS  = 19200;
  localparam logic [24:0] DEF_FB_BASE = 25'hE1000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } wr_state_t;

  // Entry layout at the default word width; the top builds the same layout at its own DATA_W.
  typedef struct packed {
    logic                  sof;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/tone_map_word_fifo.sv
// Small synchronous FIFO for assembled RAM words. Push while full is honoured
// only when a pop happens in the same cycle, leaving the occupancy unchanged.
module tone_map_word_fifo #(
  parameter int W     = 257,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tone_map_packer.sv
// Quantises tone-mapped RGB pixels, packs them into RAM words and writes the words
// into a rotating set of frame buffers. TONE_MAP_ROUND_EN selects round-half-up quantisation.
module tone_map_packer
  import tone_map_pkg::*;
#(
  parameter int                FP         = DEF_FP,
  parameter int                RED_W      = DEF_RED_W,
  parameter int                GREEN_W    = DEF_GREEN_W,
  parameter int                BLUE_W     = DEF_BLUE_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                ADDR_W     = 25,
  parameter int                ADDR_STEP  = DEF_ADDR_STEP,
  parameter logic [ADDR_W-1:0] FB_BASE    = ADDR_W'(DEF_FB_BASE),
  parameter int                FB_WORDS   = DEF_FB_WORDS,
  parameter int                N_BUF      = 2,
  parameter int                FIFO_DEPTH = 4,
  parameter bit                BYTE_SWAP  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              d_valid,
  input  logic [31:0]       d_red,
  input  logic [31:0]       d_green,
  input  logic [31:0]       d_blue,
  output logic              d_ready,
  input  logic              ram_busy,
  output logic              wr_req,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_address,
  output logic [2:0]        last_frame,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int PIX_W = RED_W + GREEN_W + BLUE_W;
  localparam int PPW   = DATA_W / PIX_W;
  localparam int PC_W  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WC_W  = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam logic [PC_W-1:0]   LAST_PIX  = PC_W'(PPW - 1);
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(FB_WORDS - 1);
  localparam logic [2:0]        LAST_BUF  = 3'(N_BUF - 1);
  localparam logic [ADDR_W-1:0] BUF_SPAN  = ADDR_W'(FB_WORDS * ADDR_STEP);

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [31:0] quant(input logic [31:0] d, input int w);
    logic [32:0] s;
    logic [32:0] mx;
`ifdef TONE_MAP_ROUND_EN
    s = ({1'b0, d} + (33'd1 << (FP - 1))) >> FP;
`else
    s = {1'b0, d} >> FP;
`endif
    mx = (33'd1 << w) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

  logic [PIX_W-1:0]  pix_raw;
  logic [PIX_W-1:0]  pix;
  logic [PC_W-1:0]   pix_cnt;
  logic [PC_W-1:0]   slot;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_d;
  logic              asm_sof;
  logic              sof_pend;
  logic              accept;
  logic              word_last;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  entry_t            push_entry;
  entry_t            pop_entry;

  always_comb begin
    pix_raw = {RED_W'(quant(d_red, RED_W)), GREEN_W'(quant(d_green, GREEN_W)),
               BLUE_W'(quant(d_blue, BLUE_W))};
    pix = pix_raw;
    if (BYTE_SWAP && (PIX_W % 8 == 0)) begin
      for (int i = 0; i < PIX_W / 8; i++) pix[i*8 +: 8] = pix_raw[PIX_W-8-i*8 +: 8];
    end
  end

  // A pixel transfers on d_valid && d_ready; d_ready only drops when the word
  // being assembled would complete into a full FIFO.
  assign d_ready = !(fifo_full && (pix_cnt == LAST_PIX));
  assign accept  = d_valid && d_ready;

  always_comb begin
    slot      = frame_start ? '0 : pix_cnt;
    word_last = (slot == LAST_PIX);
    asm_d     = asm_q;
    for (int k = 0; k < PPW; k++) begin
      if (slot == PC_W'(k)) asm_d[k*PIX_W +: PIX_W] = pix;
    end
    push            = accept && word_last;
    push_entry.data = asm_d;
    push_entry.sof  = (slot == '0) ? (sof_pend || frame_start) : asm_sof;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      asm_q    <= '0;
      asm_sof  <= 1'b0;
      sof_pend <= 1'b0;
    end else if (accept) begin
      asm_q   <= asm_d;
      pix_cnt <= word_last ? '0 : slot + 1'b1;
      if (slot == '0) begin
        asm_sof  <= sof_pend || frame_start;
        sof_pend <= 1'b0;
      end
    end else if (frame_start) begin
      pix_cnt  <= '0;
      sof_pend <= 1'b1;
    end
  end

  tone_map_word_fifo #(
    .W    (DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (pop_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  wr_state_t       state;
  wr_state_t       state_d;
  logic [2:0]      fb_idx;
  logic [2:0]      fb_eff;
  logic [2:0]      fb_wrap;
  logic [WC_W-1:0] wcnt;
  logic [WC_W-1:0] wcnt_eff;
  logic            resync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Two dead cycles after each request give the RAM controller time to raise ram_busy.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !ram_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A start-of-frame word arriving mid-buffer abandons that buffer and starts the next one.
  always_comb begin
    resync   = pop_entry.sof && (wcnt != '0);
    fb_eff   = fb_idx;
    wcnt_eff = wcnt;
    if (resync) begin
      fb_eff   = (fb_idx == LAST_BUF) ? 3'd0 : fb_idx + 3'd1;
      wcnt_eff = '0;
    end
    fb_wrap = (fb_eff == LAST_BUF) ? 3'd0 : fb_eff + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_req     <= 1'b0;
      wr_data    <= '0;
      wr_address <= FB_BASE;
      last_frame <= LAST_BUF;
      frame_done <= 1'b0;
      fb_idx     <= 3'd0;
      wcnt       <= '0;
    end else begin
      wr_req     <= pop;
      frame_done <= 1'b0;
      if (pop) begin
        wr_data    <= pop_entry.data;
        wr_address <= FB_BASE + ADDR_W'(fb_eff) * BUF_SPAN + ADDR_W'(wcnt_eff) * ADDR_W'(ADDR_STEP);
        if (wcnt_eff == LAST_WORD) begin
          last_frame <= fb_eff;
          frame_done <= 1'b1;
          fb_idx     <= fb_wrap;
          wcnt       <= '0;
        end else begin
          fb_idx <= fb_eff;
          wcnt   <= wcnt_eff + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_err <= 1'b0;
    else if ((frame_start && (pix_cnt != '0)) || (pop && resync)) sync_err <= 1'b1;
  end

endmodule

// File: tb/tb_tone_map_packer.sv
// Directed bench for tone_map_packer with 4-word frames and two buffers: frame
// rotation, quantisation table, backpressure, frame-sync recovery and reset.
module tb_tone_map_packer;

  logic         clk;
  logic         rst;
  logic         frame_start;
  logic         d_valid;
  logic [31:0]  d_red;
  logic [31:0]  d_green;
  logic [31:0]  d_blue;
  logic         d_ready;
  logic         ram_busy;
  logic         wr_req;
  logic [255:0] wr_data;
  logic [24:0]  wr_address;
  logic [2:0]   last_frame;
  logic         frame_done;
  logic         sync_err;

  int checks = 0;
  int errors = 0;

  logic [24:0]  exp_addr_q[$];
  logic [255:0] exp_data_q[$];
  logic [3:0]   exp_ctl_q[$];

  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic [15:0] pix;
  } vec_t;

  vec_t vecs[4];

  tone_map_packer #(
    .FB_BASE   (25'hE1000),
    .FB_WORDS  (4),
    .N_BUF     (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .d_valid    (d_valid),
    .d_red      (d_red),
    .d_green    (d_green),
    .d_blue     (d_blue),
    .d_ready    (d_ready),
    .ram_busy   (ram_busy),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_address (wr_address),
    .last_frame (last_frame),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rep_word(input logic [15:0] p);
    return {16{p}};
  endfunction

  function automatic logic [32:0] qz(input logic [31:0] d, input logic [32:0] mx);
    logic [32:0] s;
`ifdef TONE_MAP_ROUND_EN
    s = ({1'b0, d} + 33'h80) >> 8;
`else
    s = {1'b0, d} >> 8;
`endif
    return (s > mx) ? mx : s;
  endfunction

  function automatic logic [15:0] pix_model(input logic [31:0] r, input logic [31:0] g,
                                            input logic [31:0] b);
    logic [32:0] rq, gq, bq;
    logic [15:0] p;
    rq = qz(r, 33'd31);
    gq = qz(g, 33'd63);
    bq = qz(b, 33'd31);
    p  = {rq[4:0], gq[5:0], bq[4:0]};
    return {p[7:0], p[15:8]};
  endfunction

  task automatic bp_pix(input int i, output logic [31:0] r, output logic [31:0] g,
                        output logic [31:0] b);
    r = 32'(i % 32) << 8;
    g = 32'((i * 3) % 64) << 8;
    b = 32'((i * 7) % 32) << 8;
  endtask

  function automatic logic [255:0] bp_word(input int k);
    logic [255:0] w;
    logic [31:0]  r, g, b;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      r = 32'((k * 16 + j) % 32) << 8;
      g = 32'(((k * 16 + j) * 3) % 64) << 8;
      b = 32'(((k * 16 + j) * 7) % 32) << 8;
      w[j*16 +: 16] = pix_model(r, g, b);
    end
    return w;
  endfunction

  // Driver tasks: all input changes happen on the falling edge.
  task automatic expect_write(input logic [24:0] addr, input logic [255:0] data,
                              input logic fd, input logic [2:0] lf);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
    exp_ctl_q.push_back({fd, lf});
  endtask

  task automatic idle_inputs();
    d_valid     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic push_pixel(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                            input bit fs, output int waits);
    d_valid     = 1'b1;
    d_red       = r;
    d_green     = g;
    d_blue      = b;
    frame_start = fs;
    waits       = 0;
    while (!d_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!d_ready) begin
      checks++;
      errors++;
      $display("FAIL d_ready_timeout actual=0 expected=1");
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic stream_uniform(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                                input int n, input bit fs_first);
    int w;
    for (int i = 0; i < n; i++) push_pixel(r, g, b, fs_first && (i == 0), w);
    idle_inputs();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_addr_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_writes", 256'(exp_addr_q.size()), 256'd0);
    repeat (6) @(negedge clk);
  endtask

  // Scoreboard: every write request is matched against the expected queue.
  always @(negedge clk) begin
    logic [24:0] ea;
    logic [255:0] ed;
    logic [3:0] ec;
    if (!rst && wr_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h expected=none", wr_address);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        ec = exp_ctl_q.pop_front();
        check("wr_address", 256'(wr_address), 256'(ea));
        check("wr_data", wr_data, ed);
        check("frame_done", 256'(frame_done), 256'(ec[3]));
        check("last_frame", 256'(last_frame), 256'(ec[2:0]));
      end
    end else if (!rst && frame_done) begin
      check("frame_done_without_req", 256'(frame_done), 256'd0);
    end
  end

  initial begin
    int w;
    int waits_total;
    int n;
    logic [31:0] r, g, b;

    vecs[0] = '{32'h0000_2800, 32'h0000_0500, 32'h0000_0700, 16'hA7F8};
    vecs[2] = '{32'h0000_0000, 32'h0000_4000, 32'hFFFF_FFFF, 16'hFF07};
`ifdef TONE_MAP_ROUND_EN
    vecs[1] = '{32'h0000_0A80, 32'h0000_0000, 32'h0000_0000, 16'h0058};
    vecs[3] = '{32'h0000_01FF, 32'h0000_2A00, 32'h0000_1500, 16'h5515};
`else
    vecs[1] = '{32'h0000_0A80, 32'h0000_0000, 32'h0000_0000, 16'h0050};
    vecs[3] = '{32'h0000_01FF, 32'h0000_2A00, 32'h0000_1500, 16'h550D};
`endif

    rst         = 1'b1;
    ram_busy    = 1'b0;
    d_red       = '0;
    d_green     = '0;
    d_blue      = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_wr_req", 256'(wr_req), 256'd0);
    check("rst_wr_data", wr_data, 256'd0);
    check("rst_wr_address", 256'(wr_address), 256'hE1000);
    check("rst_last_frame", 256'(last_frame), 256'd1);
    check("rst_frame_done", 256'(frame_done), 256'd0);
    check("rst_sync_err", 256'(sync_err), 256'd0);
    check("rst_d_ready", 256'(d_ready), 256'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1 into buffer 0, frame 2 into buffer 1
    expect_write(25'hE1000, rep_word(16'hA718), 1'b0, 3'd1);
    expect_write(25'hE1004, rep_word(16'hA718), 1'b0, 3'd1);
    expect_write(25'hE1008, rep_word(16'hA718), 1'b0, 3'd1);
    expect_write(25'hE100C, rep_word(16'hA718), 1'b1, 3'd0);
    stream_uniform(32'h300, 32'h500, 32'h700, 64, 1'b1);
    wait_drain();
    expect_write(25'hE1010, rep_word(16'hA718), 1'b0, 3'd0);
    expect_write(25'hE1014, rep_word(16'hA718), 1'b0, 3'd0);
    expect_write(25'hE1018, rep_word(16'hA718), 1'b0, 3'd0);
    expect_write(25'hE101C, rep_word(16'hA718), 1'b1, 3'd1);
    stream_uniform(32'h300, 32'h500, 32'h700, 64, 1'b1);
    wait_drain();

    // Frame 3 wraps to buffer 0; one quantisation vector per word
    for (int k = 0; k < 4; k++)
      expect_write(25'hE1000 + 25'(k * 4), rep_word(vecs[k].pix), k == 3, (k == 3) ? 3'd0 : 3'd1);
    for (int k = 0; k < 4; k++) stream_uniform(vecs[k].r, vecs[k].g, vecs[k].b, 16, k == 0);
    wait_drain();

    // Backpressure: FIFO of 4 words plus 15 assembled pixels before d_ready drops
    ram_busy    = 1'b1;
    waits_total = 0;
    for (int i = 0; i < 79; i++) begin
      bp_pix(i, r, g, b);
      push_pixel(r, g, b, (i == 0) || (i == 64), w);
      waits_total += w;
    end
    check("bp_no_early_stall", 256'(waits_total), 256'd0);
    check("bp_ready_low", 256'(d_ready), 256'd0);
    bp_pix(79, r, g, b);
    d_valid = 1'b1;
    d_red   = r;
    d_green = g;
    d_blue  = b;
    repeat (5) @(negedge clk);
    check("bp_ready_held_low", 256'(d_ready), 256'd0);
    for (int k = 0; k < 8; k++)
      expect_write(((k < 4) ? 25'hE1010 : 25'hE1000) + 25'((k % 4) * 4), bp_word(k),
                   (k % 4) == 3, (k < 3) ? 3'd0 : ((k < 7) ? 3'd1 : 3'd0));
    ram_busy = 1'b0;
    for (int i = 79; i < 128; i++) begin
      bp_pix(i, r, g, b);
      push_pixel(r, g, b, 1'b0, w);
    end
    idle_inputs();
    wait_drain();
    check("bp_no_sync_err", 256'(sync_err), 256'd0);

    // Frame restart after 20 pixels: partial word dropped, buffer 1 abandoned
    expect_write(25'hE1010, rep_word(16'h4308), 1'b0, 3'd0);
    expect_write(25'hE1000, rep_word(16'hA718), 1'b0, 3'd0);
    expect_write(25'hE1004, rep_word(16'hA718), 1'b0, 3'd0);
    expect_write(25'hE1008, rep_word(16'hA718), 1'b0, 3'd0);
    expect_write(25'hE100C, rep_word(16'hA718), 1'b1, 3'd0);
    stream_uniform(32'h100, 32'h200, 32'h300, 20, 1'b1);
    check("sync_err_before_restart", 256'(sync_err), 256'd0);
    stream_uniform(32'h300, 32'h500, 32'h700, 1, 1'b1);
    check("sync_err_after_restart", 256'(sync_err), 256'd1);
    stream_uniform(32'h300, 32'h500, 32'h700, 63, 1'b0);
    wait_drain();
    check("sync_err_sticky", 256'(sync_err), 256'd1);

    // Reset while a write request is on the bus
    expect_write(25'hE1010, rep_word(16'hA718), 1'b0, 3'd0);
    stream_uniform(32'h300, 32'h500, 32'h700, 16, 1'b1);
    n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_req_seen", 256'(wr_req), 256'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_req", 256'(wr_req), 256'd0);
    check("mid_rst_wr_data", wr_data, 256'd0);
    check("mid_rst_wr_address", 256'(wr_address), 256'hE1000);
    check("mid_rst_last_frame", 256'(last_frame), 256'd1);
    check("mid_rst_frame_done", 256'(frame_done), 256'd0);
    check("mid_rst_sync_err", 256'(sync_err), 256'd0);
    check("mid_rst_d_ready", 256'(d_ready), 256'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_ctl_q.delete();
    repeat (2) @(negedge clk);
    expect_write(25'hE1000, rep_word(16'hA718), 1'b0, 3'd1);
    expect_write(25'hE1004, rep_word(16'hA718), 1'b0, 3'd1);
    expect_write(25'hE1008, rep_word(16'hA718), 1'b0, 3'd1);
    expect_write(25'hE100C, rep_word(16'hA718), 1'b1, 3'd0);
    stream_uniform(32'h300, 32'h500, 32'h700, 64, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
